// File: rtl/capture_pkg.sv
// rtl/capture_pkg.sv - shared types and default sizes for the capture sequencer
//
// Contents:
//   SAMPLE_WIDTH_DEF / ADDR_WIDTH_DEF : default sample word width and RAM address width
//   cap_state_t                       : capture sequencer state encoding (3 bits)
package capture_pkg;

    localparam int SAMPLE_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF   = 10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARMING    = 3'd1,
        ST_PRETRIG   = 3'd2,
        ST_WAIT_TRIG = 3'd3,
        ST_POSTTRIG  = 3'd4,
        ST_DONE      = 3'd5
    } cap_state_t;

endpackage

// File: rtl/capture_sequencer_if.sv
// rtl/capture_sequencer_if.sv - sample input strobe and sample RAM write bus
//
// Signals:
//   valid, dataIn               : qualified sample stream (also feeds trigger_basic)
//   mem_we, mem_addr, mem_data  : write port of the external sample RAM
// Modports:
//   master : the capture sequencer (consumes samples, drives the RAM write port)
//   slave  : the environment (produces samples, observes the RAM write port)
interface capture_sequencer_if
    import capture_pkg::*;
#(
    parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
    parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF
) ();

    logic                    valid;
    logic [SAMPLE_WIDTH-1:0] dataIn;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [SAMPLE_WIDTH-1:0] mem_data;

    modport master (
        input  valid,
        input  dataIn,
        output mem_we,
        output mem_addr,
        output mem_data
    );

    modport slave (
        output valid,
        output dataIn,
        input  mem_we,
        input  mem_addr,
        input  mem_data
    );

endinterface

// File: rtl/capture_sequencer_wrap_counter.sv
// rtl/capture_sequencer_wrap_counter.sv - modulo-2**WIDTH address pointer with clear and increment
//
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   clear        : force the pointer to 0 next cycle (wins over inc)
//   inc          : advance the pointer by one, wrapping 2**WIDTH-1 -> 0
//   count        : current pointer value
module wrap_counter #(
    parameter int WIDTH = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc) begin
            // Natural overflow of the WIDTH-bit add gives the wrap.
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/capture_sequencer.sv
// rtl/capture_sequencer.sv - circular-buffer capture sequencer downstream of trigger_basic
//
// Ports:
//   clock, reset            : system clock, synchronous active-high reset
//   start, abort            : begin a capture (IDLE/DONE only) / cancel back to IDLE
//   pre_count, post_count   : pre-trigger and post-trigger sample counts, latched on start
//   run                     : trigger hit from trigger_basic (level, sampled in WAIT_TRIG)
//   arm                     : one-cycle arm pulse to trigger_basic
//   busy, done              : capture in progress / capture complete (level)
//   trig_addr, start_addr   : first post-trigger address / oldest valid sample address
//   bus                     : sample input and sample RAM write port
module capture_sequencer
    import capture_pkg::*;
#(
    parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
    parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH:0]   pre_count,
    input  logic [ADDR_WIDTH:0]   post_count,
    input  logic                  run,
    output logic                  arm,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] trig_addr,
    output logic [ADDR_WIDTH-1:0] start_addr,
    capture_sequencer_if.master   bus
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    cap_state_t            state_q, state_d;
    logic [CW-1:0]         pre_q, pre_d;
    logic [CW-1:0]         post_q, post_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] trig_addr_q, trig_addr_d;
    logic [ADDR_WIDTH-1:0] start_addr_q, start_addr_d;
    logic                  arm_q, arm_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [CW-1:0]         pre_clamped;
    logic [CW-1:0]         room;
    logic [CW-1:0]         post_clamped;
    logic [CW-1:0]         cnt_inc;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic                  in_capture;
    logic                  trig_hit;
    logic                  write_en;
    logic                  start_ok;

    // Clamp so that pre + post never exceeds the buffer depth; a pre larger
    // than the buffer fills it entirely and leaves no room for post samples.
    always_comb begin
        pre_clamped  = (pre_count > CW'(DEPTH)) ? CW'(DEPTH) : pre_count;
        room         = CW'(DEPTH) - pre_clamped;
        post_clamped = (post_count > room) ? room : post_count;
    end

    // The trigger cycle with post == 0 must not write: that sample would
    // overwrite the oldest pre-trigger sample of a full history.
    always_comb begin
        in_capture = (state_q == ST_PRETRIG) || (state_q == ST_WAIT_TRIG) ||
                     (state_q == ST_POSTTRIG);
        trig_hit   = (state_q == ST_WAIT_TRIG) && run;
        write_en   = in_capture && bus.valid && !(trig_hit && (post_q == '0));
        cnt_inc    = cnt_q + 1'b1;
    end

    wrap_counter #(
        .WIDTH (ADDR_WIDTH)
    ) u_wr_ptr (
        .clock (clock),
        .reset (reset),
        .clear (start_ok),
        .inc   (write_en),
        .count (wr_ptr)
    );

    always_comb begin
        state_d      = state_q;
        pre_d        = pre_q;
        post_d       = post_q;
        cnt_d        = cnt_q;
        trig_addr_d  = trig_addr_q;
        start_addr_d = start_addr_q;
        start_ok     = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        start_ok = 1'b1;
                        state_d  = ST_ARMING;
                        pre_d    = pre_clamped;
                        post_d   = post_clamped;
                        cnt_d    = '0;
                    end
                end
                ST_ARMING: begin
                    state_d = (pre_q != '0) ? ST_PRETRIG : ST_WAIT_TRIG;
                end
                ST_PRETRIG: begin
                    if (write_en) begin
                        if (cnt_inc == pre_q) begin
                            state_d = ST_WAIT_TRIG;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                ST_WAIT_TRIG: begin
                    if (run) begin
                        trig_addr_d = wr_ptr;
                        // A valid trigger-cycle sample is post sample 1, so a
                        // single-sample post window can finish right here.
                        if ((post_q == '0) || (write_en && (post_q == CW'(1)))) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_POSTTRIG;
                            cnt_d   = write_en ? CW'(1) : '0;
                        end
                    end
                end
                ST_POSTTRIG: begin
                    if (write_en) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == post_q) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // trig_addr_d, not trig_addr_q: DONE can be entered straight from
        // the trigger cycle.
        if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
            start_addr_d = trig_addr_d - pre_q[ADDR_WIDTH-1:0];
        end

        arm_d  = (state_d == ST_ARMING);
        busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pre_q        <= '0;
            post_q       <= '0;
            cnt_q        <= '0;
            trig_addr_q  <= '0;
            start_addr_q <= '0;
            arm_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pre_q        <= pre_d;
            post_q       <= post_d;
            cnt_q        <= cnt_d;
            trig_addr_q  <= trig_addr_d;
            start_addr_q <= start_addr_d;
            arm_q        <= arm_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.mem_we   = write_en;
    assign bus.mem_addr = wr_ptr;
    assign bus.mem_data = write_en ? bus.dataIn : '0;
    assign arm          = arm_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign trig_addr    = trig_addr_q;
    assign start_addr   = start_addr_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// tb/tb_capture_sequencer.sv - self-checking bench for capture_sequencer
module tb_capture_sequencer;

    localparam int SW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int MAXC  = 160;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          run   = 1'b0;
    logic [AW:0]   pre_count  = '0;
    logic [AW:0]   post_count = '0;
    logic          arm, busy, done;
    logic [AW-1:0] trig_addr, start_addr;

    capture_sequencer_if #(.SAMPLE_WIDTH(SW), .ADDR_WIDTH(AW)) bus ();

    capture_sequencer #(.SAMPLE_WIDTH(SW), .ADDR_WIDTH(AW)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .pre_count  (pre_count),
        .post_count (post_count),
        .run        (run),
        .arm        (arm),
        .busy       (busy),
        .done       (done),
        .trig_addr  (trig_addr),
        .start_addr (start_addr),
        .bus        (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int arm_cnt = 0;

    bit            vld_a [MAXC];
    bit            run_a [MAXC];
    logic [SW-1:0] dat_a [MAXC];

    logic [AW-1:0] exp_addr[$];
    logic [SW-1:0] exp_data[$];
    logic [AW-1:0] got_addr[$];
    logic [SW-1:0] got_data[$];
    int exp_trig, exp_start, exp_done_c;

    initial begin
        #1000000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1);
    end

    always @(negedge clock) begin
        if (bus.mem_we) begin
            got_addr.push_back(bus.mem_addr);
            got_data.push_back(bus.mem_data);
        end
        if (arm) arm_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: after clamping, every valid sample before the trigger cycle
    // is written, then the first post_l valid samples from the trigger cycle
    // on; write k lands at address k mod DEPTH.
    task automatic compute_model(input int pre, input int post);
        int pre_l, post_l, c, seen, t, n;
        pre_l  = (pre > DEPTH) ? DEPTH : pre;
        post_l = (pre_l + post > DEPTH) ? DEPTH - pre_l : post;
        exp_addr.delete();
        exp_data.delete();
        c = 0;
        seen = 0;
        while (seen < pre_l && c < MAXC) begin
            if (vld_a[c]) seen++;
            c++;
        end
        while (c < MAXC && !run_a[c]) c++;
        t = c;
        for (int k = 0; k < t && k < MAXC; k++) begin
            if (vld_a[k]) begin
                exp_addr.push_back(AW'(exp_addr.size() % DEPTH));
                exp_data.push_back(dat_a[k]);
            end
        end
        exp_trig  = exp_addr.size() % DEPTH;
        exp_start = (exp_trig - pre_l + DEPTH) % DEPTH;
        if (post_l == 0) begin
            exp_done_c = t + 1;
        end else begin
            n = 0;
            c = t;
            while (n < post_l && c < MAXC) begin
                if (vld_a[c]) begin
                    exp_addr.push_back(AW'(exp_addr.size() % DEPTH));
                    exp_data.push_back(dat_a[c]);
                    n++;
                end
                c++;
            end
            exp_done_c = c;
        end
    endtask

    task automatic begin_capture(input int pre, input int post);
        @(posedge clock); #1;
        got_addr.delete();
        got_data.delete();
        arm_cnt    = 0;
        start      = 1'b1;
        abort      = 1'b0;
        pre_count  = (AW+1)'(pre);
        post_count = (AW+1)'(post);
        bus.valid  = 1'b0;
        run        = 1'b0;
        @(posedge clock); #1;
        start      = 1'b0;
        bus.valid  = 1'b1;
        bus.dataIn = 8'hA5;
        run        = 1'b1;
        pre_count  = (AW+1)'($urandom);
        post_count = (AW+1)'($urandom);
        @(negedge clock);
        chk("arming_arm", arm, 1);
        chk("arming_no_write", bus.mem_we, 0);
        chk("arming_busy", busy, 1);
    endtask

    task automatic step(input int c);
        @(posedge clock); #1;
        abort      = 1'b0;
        bus.valid  = vld_a[c];
        bus.dataIn = dat_a[c];
        run        = run_a[c];
        @(negedge clock);
    endtask

    task automatic run_capture(input int pre, input int post);
        int done_c;
        int nmin;
        compute_model(pre, post);
        begin_capture(pre, post);
        done_c = -1;
        for (int c = 0; c < MAXC; c++) begin
            step(c);
            if (done) begin
                done_c = c;
                chk("done_no_write", bus.mem_we, 0);
                break;
            end
        end
        chk("done_cycle", done_c, exp_done_c);
        chk("done_busy", busy, 0);
        chk("write_count", got_addr.size(), exp_addr.size());
        nmin = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
        for (int i = 0; i < nmin; i++) begin
            chk("write_addr", got_addr[i], exp_addr[i]);
            chk("write_data", got_data[i], exp_data[i]);
        end
        chk("trig_addr", trig_addr, exp_trig);
        chk("start_addr", start_addr, exp_start);
        chk("arm_pulses", arm_cnt, 1);
    endtask

    task automatic fill(input int vmode, input int run_from);
        for (int c = 0; c < MAXC; c++) begin
            vld_a[c] = (vmode == 0) ? 1'b1 : (c % 2 == 0);
            run_a[c] = (c >= run_from);
            dat_a[c] = SW'($urandom);
        end
    endtask

    task automatic fill_random();
        for (int c = 0; c < MAXC; c++) begin
            vld_a[c] = (c >= 100) ? 1'b1 : ($urandom_range(3) != 0);
            run_a[c] = (c >= 100) ? 1'b1 : ($urandom_range(7) == 0);
            dat_a[c] = SW'($urandom);
        end
    endtask

    initial begin
        bus.valid  = 1'b1;
        bus.dataIn = 8'h3C;
        start      = 1'b1;
        abort      = 1'b1;
        reset      = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clock);
        chk("reset_arm", arm, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_we", bus.mem_we, 0);
        chk("reset_addr", bus.mem_addr, 0);
        chk("reset_data", bus.mem_data, 0);
        chk("reset_trig", trig_addr, 0);
        chk("reset_start", start_addr, 0);

        // pre=4 post=4, trigger on the 10th WAIT_TRIG cycle
        fill(0, 13);
        run_capture(4, 4);
        chk("tp1_trig", trig_addr, 13);
        chk("tp1_start", start_addr, 9);

        // run high throughout PRETRIG is ignored
        fill(0, 0);
        run_capture(3, 2);
        chk("tp2_trig", trig_addr, 3);
        chk("tp2_start", start_addr, 0);

        // alternating valid; trigger on an invalid cycle
        fill(1, 7);
        run_capture(2, 2);

        // post clamped to DEPTH-pre
        fill(0, 20);
        run_capture(12, 10);

        // pre=0 post=0
        fill(0, 3);
        run_capture(0, 0);
        chk("tp5_trig", trig_addr, 3);
        chk("tp5_start", start_addr, 3);

        // start and abort together from DONE: abort wins
        @(posedge clock); #1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clock);
        chk("startabort_busy", busy, 0);
        chk("startabort_done", done, 0);
        chk("startabort_arm", arm, 0);

        // abort in POSTTRIG
        fill(0, 4);
        begin_capture(2, 8);
        for (int c = 0; c < 7; c++) step(c);
        @(posedge clock); #1;
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        @(negedge clock);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_we", bus.mem_we, 0);

        // reset during WAIT_TRIG
        fill(0, MAXC);
        begin_capture(3, 3);
        for (int c = 0; c < 6; c++) step(c);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("midreset_busy", busy, 0);
        chk("midreset_done", done, 0);
        chk("midreset_we", bus.mem_we, 0);
        chk("midreset_addr", bus.mem_addr, 0);
        chk("midreset_trig", trig_addr, 0);

        // re-arm after reset: first write must land at address 0
        fill(0, 5);
        run_capture(1, 2);

        for (int i = 0; i < 12; i++) begin
            fill_random();
            run_capture($urandom_range(31), $urandom_range(31));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
